// File: rtl/sha_round_ctrl.sv
// sha_round_ctrl: job wrapper and round sequencer for the SHA-256 sha_unit.
// Define SHA_CTRL_OUTPUT_BUFFER_EN for a two-entry digest queue (else one).
module sha_round_ctrl (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] in_m,
  input  logic [255:0] in_h0,
  output logic [5:0]   round,
  output logic [31:0]  kt,
  output logic [511:0] m,
  output logic [255:0] h0,
  input  logic [255:0] h1,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] out_digest,
  output logic         busy
);

`ifdef SHA_CTRL_OUTPUT_BUFFER_EN
  localparam logic [1:0] DEPTH = 2'd2;
`else
  localparam logic [1:0] DEPTH = 2'd1;
`endif

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t         r_state;
  state_t         w_state_nx;
  logic [6:0]     r_p;
  logic [5:0]     r_round;
  logic [31:0]    r_kt;
  logic [511:0]   r_m;
  logic [255:0]   r_h0;
  logic [1:0]     r_cnt;
  logic [255:0]   r_q0;
  logic [255:0]   r_q1;
  logic           w_accept;
  logic           w_done;
  logic           w_pop;
  logic [6:0]     w_p_inc;

  assign in_ready   = (r_state == S_IDLE) && (r_cnt < DEPTH);
  assign busy       = (r_state == S_RUN);
  assign out_valid  = (r_cnt != 2'd0);
  assign out_digest = r_q0;
  assign round      = r_round;
  assign kt         = r_kt;
  assign m          = r_m;
  assign h0         = r_h0;
  assign w_pop      = out_valid && out_ready;
  assign w_p_inc    = r_p + 7'd1;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_accept   = 1'b0;
    w_done     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          w_accept   = 1'b1;
          w_state_nx = S_RUN;
        end
      end
      S_RUN: begin
        if (r_p == 7'd64) begin
          w_done     = 1'b1;
          w_state_nx = S_IDLE;
        end
      end
      default: ;
    endcase
  end

  // round saturates at 63 so the datapath sees round 63 twice at the end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_p     <= '0;
      r_round <= '0;
      r_kt    <= '0;
      r_m     <= '0;
      r_h0    <= '0;
    end else if (w_accept) begin
      r_m     <= in_m;
      r_h0    <= in_h0;
      r_p     <= '0;
      r_round <= '0;
      r_kt    <= '0;
    end else if (r_state == S_RUN && !r_p[6]) begin
      r_p     <= w_p_inc;
      r_round <= w_p_inc[6] ? 6'd63 : w_p_inc[5:0];
      r_kt    <= K[r_p[5:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_q0  <= '0;
      r_q1  <= '0;
    end else begin
      unique case ({w_done, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) r_q0 <= h1;
          else               r_q1 <= h1;
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_q0  <= r_q1;
          r_cnt <= r_cnt - 2'd1;
        end
        2'b11: begin
          if (r_cnt == 2'd1) begin
            r_q0 <= h1;
          end else begin
            r_q0 <= r_q1;
            r_q1 <= h1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha_round_ctrl.sv
// tb_sha_round_ctrl: drives sha_round_ctrl against a behavioural sha_unit
// and a plain SHA-256 compression reference.
module tb_sha_round_ctrl;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [511:0] in_m = '0;
  logic [255:0] in_h0 = '0;
  logic [5:0]   round;
  logic [31:0]  kt;
  logic [511:0] m;
  logic [255:0] h0;
  logic [255:0] h1;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [255:0] out_digest;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [255:0] IV =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [511:0] ABC = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMPTY = {32'h80000000, 480'h0};
  localparam logic [255:0] ABC_D =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY_D =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

`ifdef SHA_CTRL_OUTPUT_BUFFER_EN
  localparam int GAP = 66;
`else
  localparam int GAP = 67;
`endif

  sha_round_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_m       (in_m),
    .in_h0      (in_h0),
    .round      (round),
    .kt         (kt),
    .m          (m),
    .h0         (h0),
    .h1         (h1),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_digest (out_digest),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sched_w(input logic [511:0] mb,
                                          input int t);
    logic [31:0] w [64];
    for (int i = 0; i < 64; i++) begin
      if (i < 16) w[i] = mb[511 - 32*i -: 32];
      else w[i] = (rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10))
                + w[i-7]
                + (rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3))
                + w[i-16];
    end
    return w[t];
  endfunction

  function automatic logic [255:0] rnd(input logic [255:0] s,
                                       input logic [31:0] w,
                                       input logic [31:0] k);
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    {a, b, c, d, e, f, g, h} = s;
    t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25))
           + ((e & f) ^ (~e & g)) + k + w;
    t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22))
           + ((a & b) ^ (a & c) ^ (b & c));
    return {t1 + t2, a, b, c, d + t1, e, f, g};
  endfunction

  function automatic logic [255:0] add8(input logic [255:0] x,
                                        input logic [255:0] y);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
    return r;
  endfunction

  function automatic logic [255:0] sha_ref(input logic [511:0] mb,
                                           input logic [255:0] hb);
    logic [255:0] s;
    s = hb;
    for (int t = 0; t < 64; t++) s = rnd(s, sched_w(mb, t), KT[t]);
    return add8(hb, s);
  endfunction

  // behavioural sha_unit: load on round 0, one round per edge otherwise
  logic [255:0] st;
  logic [31:0]  wt;
  always @(posedge clk) begin
    if (round == 6'd0) begin
      st <= h0;
      wt <= sched_w(m, 0);
    end else begin
      st <= rnd(st, wt, kt);
      wt <= sched_w(m, int'(round));
    end
  end
  always_comb h1 = add8(h0, rnd(st, wt, kt));

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input logic [511:0] bm, input logic [255:0] bh);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      tick;
      n++;
    end
    chk("send_ready", in_ready, 1);
    in_valid = 1'b1;
    in_m     = bm;
    in_h0    = bh;
    tick;
    in_valid = 1'b0;
  endtask

  logic [511:0] jm [3];
  logic [255:0] jh [3];
  logic [255:0] exp_q [$];
  int           acc_q [$];
  logic [511:0] cur_m;
  logic [255:0] cur_h;
  logic [31:0]  exp_kt;
  logic         acc;
  int           j, got, last_acc;

  initial begin
    tick;
    tick;
    reset = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_round", round, 0);
    chk("rst_kt", kt, 0);
    chk("rst_m", m, 0);
    chk("rst_h0", h0, 0);
    chk("rst_digest", out_digest, 0);

    // "abc" with full schedule check, downstream stalled
    send(ABC, IV);
    for (int k = 0; k <= 64; k++) begin
      if (k == 0) exp_kt = 32'h0;
      else        exp_kt = KT[k-1];
      chk("sched_round", round, (k > 63) ? 63 : k);
      chk("sched_kt", kt, exp_kt);
      chk("sched_busy", busy, 1);
      chk("sched_in_ready", in_ready, 0);
      chk("sched_out_valid", out_valid, 0);
      tick;
    end
    chk("abc_valid", out_valid, 1);
    chk("abc_digest", out_digest, ABC_D);
    chk("abc_busy", busy, 0);

`ifdef SHA_CTRL_OUTPUT_BUFFER_EN
    chk("bp_ready_e66", in_ready, 1);
    send(EMPTY, IV);
    repeat (65) tick;
    chk("bp_valid", out_valid, 1);
    chk("bp_head_abc", out_digest, ABC_D);
    out_ready = 1'b1;
    tick;
    chk("bp_valid2", out_valid, 1);
    chk("bp_empty_digest", out_digest, EMPTY_D);
    tick;
    out_ready = 1'b0;
    chk("bp_drained", out_valid, 0);
`else
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("bp_hold_ready", in_ready, 0);
      chk("bp_hold_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk("bp_ready_after_pop", in_ready, 1);
    chk("bp_popped", out_valid, 0);
    send(EMPTY, IV);
    repeat (65) tick;
    chk("bp_valid", out_valid, 1);
    chk("bp_empty_digest", out_digest, EMPTY_D);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk("bp_drained", out_valid, 0);
`endif

    // random back-to-back jobs, downstream always ready,
    // next job's data held on in_m/in_h0 while the current one runs
    for (int i = 0; i < 3; i++) begin
      for (int w = 0; w < 16; w++) jm[i][32*w +: 32] = $urandom;
      for (int w = 0; w < 8; w++) jh[i][32*w +: 32] = $urandom;
    end
    out_ready = 1'b1;
    j = 0;
    got = 0;
    last_acc = -1;
    cur_m = '0;
    cur_h = '0;
    in_valid = 1'b1;
    in_m = jm[0];
    in_h0 = jh[0];
    for (int c = 0; c < 400 && got < 3; c++) begin
      if (out_valid) begin
        chk("rand_spurious", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          chk("rand_digest", out_digest, exp_q[0]);
          chk("rand_latency", cyc - acc_q[0], 65);
          void'(exp_q.pop_front());
          void'(acc_q.pop_front());
          got++;
        end
      end
      if (busy) begin
        chk("ign_m", m, cur_m);
        chk("ign_h0", h0, cur_h);
      end
      acc = in_valid && in_ready;
      tick;
      if (acc) begin
        exp_q.push_back(sha_ref(in_m, in_h0));
        acc_q.push_back(cyc);
        if (last_acc >= 0) chk("rand_interval", cyc - last_acc, GAP);
        last_acc = cyc;
        cur_m = in_m;
        cur_h = in_h0;
        j++;
        if (j < 3) begin
          in_m  = jm[j];
          in_h0 = jh[j];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    chk("rand_done", got, 3);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick;

    // reset in the middle of a job (with a queued digest when buffered)
`ifdef SHA_CTRL_OUTPUT_BUFFER_EN
    send(ABC, IV);
    repeat (65) tick;
`endif
    send(EMPTY, IV);
    repeat (30) tick;
    chk("mid_round30", round, 30);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("mid_out_valid", out_valid, 0);
    chk("mid_round", round, 0);
    chk("mid_kt", kt, 0);
    chk("mid_in_ready", in_ready, 1);
    chk("mid_busy", busy, 0);

    send(ABC, IV);
    repeat (65) tick;
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_digest", out_digest, ABC_D);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk("post_rst_drained", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
